// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// Module : alu_seq_pkg
// Brief  : Shared types and constants for the ALU multiply sequencer.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_A  = 3'd1,
    ABS_B  = 3'd2,
    MUL    = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } mul_state_t;

  localparam logic [2:0] ALU_ROL = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_ROR = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam int MUL_ITERS = 16;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// Module : alu_mul_seq
// Brief  : Shift-and-add 16x16 multiplier sequencing the external shared ALU.
//          Optional signed support via `define MUL_SIGNED_EN.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_mul_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  input  logic             sgn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_Op,
  output logic             alu_Cin,
  output logic             alu_invA,
  output logic             alu_invB,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_Out,
  input  logic             alu_cout
);

  localparam int CNT_W = $clog2(MUL_ITERS);

  mul_state_t       r_state;
  mul_state_t       w_next;
  logic [WIDTH-1:0] r_mcand;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(MUL_ITERS - 1));

`ifdef MUL_SIGNED_EN
  logic r_neg;
  logic r_borrow;
`else
  logic w_unused_sgn;
  assign w_unused_sgn = sgn;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef MUL_SIGNED_EN
          w_next = sgn ? ABS_A : MUL;
`else
          w_next = MUL;
`endif
        end
      end
`ifdef MUL_SIGNED_EN
      ABS_A:  w_next = ABS_B;
      ABS_B:  w_next = MUL;
      MUL:    if (w_last) w_next = r_neg ? NEG_LO : DONE;
      NEG_LO: w_next = NEG_HI;
      NEG_HI: w_next = DONE;
`else
      MUL:    if (w_last) w_next = DONE;
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ALU drive depends on state and registers only, never on start.
  always_comb begin
    busy     = (r_state != IDLE);
    done     = (r_state == DONE);
    alu_A    = '0;
    alu_B    = '0;
    alu_Op   = ALU_ADD;
    alu_Cin  = 1'b0;
    alu_invA = 1'b0;
    alu_invB = 1'b0;
    alu_sign = 1'b0;
    case (r_state)
      MUL: begin
        alu_A = prod_hi;
        alu_B = prod_lo[0] ? r_mcand : '0;
      end
`ifdef MUL_SIGNED_EN
      ABS_A: begin
        if (r_mcand[WIDTH-1]) begin
          alu_A    = r_mcand;
          alu_invA = 1'b1;
          alu_Cin  = 1'b1;
        end
      end
      ABS_B: begin
        if (prod_lo[WIDTH-1]) begin
          alu_A    = prod_lo;
          alu_invA = 1'b1;
          alu_Cin  = 1'b1;
        end
      end
      NEG_LO: begin
        alu_A    = prod_lo;
        alu_invA = 1'b1;
        alu_Cin  = 1'b1;
      end
      NEG_HI: begin
        alu_A    = prod_hi;
        alu_invA = 1'b1;
        alu_Cin  = r_borrow;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_hi  <= '0;
      prod_lo  <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
`ifdef MUL_SIGNED_EN
      r_neg    <= 1'b0;
      r_borrow <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= mcand;
            prod_lo <= mplier;
            prod_hi <= '0;
            r_cnt   <= '0;
`ifdef MUL_SIGNED_EN
            r_neg   <= sgn & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
`endif
          end
        end
        MUL: begin
          // Carry-out becomes the new top bit as the pair shifts right.
          {prod_hi, prod_lo} <= {alu_cout, alu_Out, prod_lo[WIDTH-1:1]};
          r_cnt              <= r_cnt + CNT_W'(1);
        end
`ifdef MUL_SIGNED_EN
        ABS_A:  if (r_mcand[WIDTH-1]) r_mcand <= alu_Out;
        ABS_B:  if (prod_lo[WIDTH-1]) prod_lo <= alu_Out;
        NEG_LO: begin
          prod_lo  <= alu_Out;
          r_borrow <= alu_cout;
        end
        NEG_HI: prod_hi <= alu_Out;
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// ---------------------------------------------------------------------------
// Module : tb_alu_mul_seq
// Brief  : Self-checking bench for alu_mul_seq with a behavioural ALU and
//          product/latency model. Honours `define MUL_SIGNED_EN.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_mul_seq;

`ifdef MUL_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic        sgn    = 1'b0;
  logic [15:0] mcand  = '0;
  logic [15:0] mplier = '0;
  logic        busy, done;
  logic [15:0] prod_hi, prod_lo, alu_A, alu_B, alu_Out;
  logic [2:0]  alu_Op;
  logic        alu_Cin, alu_invA, alu_invB, alu_sign, alu_cout;
  logic [16:0] alu_sum;

  int n_cmp  = 0;
  int n_bad  = 0;
  int cyc_now = 0;

  alu_mul_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .sgn(sgn), .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op), .alu_Cin(alu_Cin),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
    .alu_Out(alu_Out), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now++;

  // External ALU add path
  always_comb begin
    alu_sum = {1'b0, alu_invA ? ~alu_A : alu_A}
            + {1'b0, alu_invB ? ~alu_B : alu_B}
            + {16'd0, alu_Cin};
  end
  assign alu_Out  = alu_sum[15:0];
  assign alu_cout = alu_sum[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input bit s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b, input bit s);
    if (!s) return 17;
    return (a[15] ^ b[15]) ? 21 : 19;
  endfunction

  // Model: cycles left until done (0 = idle) and the result to be shown.
  int          m_left = 0;
  logic [31:0] m_res  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_res  = '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left = ref_lat(mcand, mplier, SIGNED_BUILD && sgn);
        m_res  = ref_prod(mcand, mplier, SIGNED_BUILD && sgn);
      end
    end else begin
      m_left = m_left - 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_left != 0);
    chk("done", done, m_left == 1);
    chk("alu_Op", alu_Op, 3'b100);
    chk("alu_invB", alu_invB, 1'b0);
    chk("alu_sign", alu_sign, 1'b0);
    if (m_left <= 1) chk("prod", {prod_hi, prod_lo}, m_res);
    if (m_left == 0) chk("alu_idle", {alu_A, alu_B, alu_Cin, alu_invA}, '0);
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit s,
                        input logic [31:0] exp_p, input int exp_lat, input bit pulse,
                        output int done_cyc);
    int c;
    @(posedge clk); #1;
    start = 1'b1; mcand = a; mplier = b; sgn = s;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (!done) chk("busy_during_op", busy, 1'b1);
      start = pulse && (c == 5 || c == 17);
    end while (!done && c < 60);
    chk("latency", c, exp_lat);
    chk("product", {prod_hi, prod_lo}, exp_p);
    done_cyc = cyc_now;
    if (pulse) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int d1, d2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_prod", {prod_hi, prod_lo}, 32'h0);
    chk("rst_alu", {alu_A, alu_B, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign},
        {16'h0, 16'h0, 3'b100, 4'b0});
    rst = 1'b0;

    run_op(16'd3, 16'd5, 1'b0, 32'h0000_000F, 17, 1'b0, d1);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 17, 1'b0, d1);
    run_op(16'h0000, 16'h1234, 1'b0, 32'h0000_0000, 17, 1'b0, d1);
    run_op(16'h8000, 16'h0002, 1'b0, 32'h0001_0000, 17, 1'b0, d2);
    chk("b2b_done_gap", d2 - d1, 18);

`ifdef MUL_SIGNED_EN
    run_op(16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1, 21, 1'b0, d1);
    run_op(16'hFFFD, 16'hFFFB, 1'b1, 32'h0000_000F, 19, 1'b0, d1);
    run_op(16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000, 21, 1'b0, d1);
`else
    run_op(16'hFFFD, 16'h0005, 1'b1, 32'h0004_FFF1, 17, 1'b0, d1);
`endif

    run_op(16'd3, 16'd5, 1'b0, 32'h0000_000F, 17, 1'b1, d1);
    repeat (3) @(negedge clk);

    // Reset in the middle of an operation
    @(posedge clk); #1;
    start = 1'b1; mcand = 16'h1234; mplier = 16'h5678; sgn = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_prod", {prod_hi, prod_lo}, 32'h0);
    chk("midrst_alu", {alu_A, alu_B, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign},
        {16'h0, 16'h0, 3'b100, 4'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(16'd7, 16'd7, 1'b0, 32'h0000_0031, 17, 1'b0, d1);

    // Random traffic; the per-cycle compare tracks every accepted start
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 3) == 0);
      mcand  = pick();
      mplier = pick();
      sgn    = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 16×16 shift-and-add multiplier controller that sequences the shared 16-bit ALU, using its add path one bit per cycle to form a 32-bit product. It sits beside the ALU in the execute stage and owns the ALU's operand and control inputs while busy; the pipeline stalls on `busy`. The ALU is instantiated outside this block, which drives its inputs and samples its `Out` and `c_out`.

## Interface
- `WIDTH`, 16: operand width; product is 2×WIDTH. Only 16 is supported.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a multiply; sampled only in IDLE.
- `mcand` in 16: multiplicand, captured on start.
- `mplier` in 16: multiplier, captured on start.
- `sgn` in 1: signed request, captured on start. Ignored unless `MUL_SIGNED_EN` is defined.
- `busy` out 1: high from the cycle after start acceptance through DONE.
- `done` out 1: one-cycle pulse in DONE.
- `prod_hi`, `prod_lo` out 16 each: product registers, held until the next accepted start.
- `alu_A`, `alu_B` out 16: ALU operands.
- `alu_Op` out 3: ALU operation.
- `alu_Cin`, `alu_invA`, `alu_invB`, `alu_sign` out 1 each: ALU controls.
- `alu_Out` in 16: ALU result.
- `alu_cout` in 1: ALU carry out.

## Operation
- Reset (asynchronous) values:
  - state IDLE; `busy`, `done` = 0.
  - `prod_hi`, `prod_lo`, internal multiplicand register, and counter = 0.
  - ALU drive: `alu_A`, `alu_B` = 0; `alu_Op` = 3'b100 (add); `alu_Cin`, `alu_invA`, `alu_invB`, `alu_sign` = 0.
- ALU drive is a combinational function of the current state and registers only. It never depends on `start`.
- `alu_Op` = 3'b100 in all states. `alu_invB` = 0 and `alu_sign` = 0 always.
- IDLE:
  - On `start`, capture `mcand` into the multiplicand register M.
  - Set `prod_lo` = `mplier`, `prod_hi` = 0, counter = 0, and latch the result-sign flag: `sgn & (mcand[15] ^ mplier[15])`.
  - Next state is ABS_A if signed, otherwise MUL.
- ABS_A (signed only):
  - If M[15]: drive `alu_A` = M, `alu_invA` = 1, `alu_B` = 0, `alu_Cin` = 1, and load M ← `alu_Out`.
  - Go to ABS_B.
- ABS_B (signed only): same negation applied to `prod_lo` when `prod_lo[15]` is set. Go to MUL.
- MUL, 16 iterations:
  - Drive `alu_A` = `prod_hi`, `alu_B` = `prod_lo[0]` ? M : 0, `alu_Cin` = 0.
  - Update {`prod_hi`, `prod_lo`} ← {`alu_cout`, `alu_Out`, `prod_lo[15:1]`}.
  - Counter increments. When counter reaches 15, go to NEG_LO if the result-sign flag is set, otherwise DONE.
- NEG_LO:
  - Drive `alu_A` = `prod_lo`, `alu_invA` = 1, `alu_B` = 0, `alu_Cin` = 1.
  - `prod_lo` ← `alu_Out`; latch `alu_cout` into the borrow flag.
- NEG_HI: same as NEG_LO on `prod_hi`, with `alu_Cin` = borrow flag.
- DONE: `done` = 1 and `busy` = 1; go to IDLE unconditionally.
- Arithmetic rules:
  - Unsigned product is exact across the full 32 bits.
  - The −32768 magnitude is 0x8000, which is correct when treated as unsigned.
  - The ALU `Ofl` output is unused.

## Timing
- Start accepted at edge 0.
- Unsigned: MUL covers cycles 1–16; `done` in cycle 17; IDLE in cycle 18. Latency is 17.
- Signed with `MUL_SIGNED_EN`:
  - ABS_A and ABS_B in cycles 1–2, MUL in 3–18.
  - With a negative result: NEG_LO and NEG_HI in 19–20, `done` in 21.
  - With a non-negative result: `done` in 19.
- `start` while not in IDLE (including DONE) is ignored and is not queued. A new start is accepted in the first IDLE cycle.
- `prod_*` change only during an operation. They are valid in the `done` cycle and are held afterward.
- `rst` mid-operation returns the block immediately to IDLE with reset values; the partial product is discarded.

## Configuration
- `MUL_SIGNED_EN`:
  - Defined: `sgn` is honoured, and the ABS_A, ABS_B, NEG_LO and NEG_HI states plus the sign and borrow flags are built.
  - Undefined: `sgn` is ignored, those states and flags are absent, and every operation is unsigned with 17-cycle latency.

## Structure
- Shared package `alu_seq_pkg`:
  - State enum: IDLE, ABS_A, ABS_B, MUL, NEG_LO, NEG_HI, DONE.
  - ALU opcode constants: `ALU_ADD`=3'b100, `ALU_OR`=3'b101, `ALU_XOR`=3'b110, `ALU_AND`=3'b111, shifts 3'b000–3'b011.
  - `MUL_ITERS`=16.
- Single module, no sub-module. The ALU stays external so the execute stage can mux it with the normal path on `busy`.

## Test plan
- Unsigned 3 × 5, start at cycle 0 → `done` at cycle 17; `prod_hi`=0x0000, `prod_lo`=0x000F; `busy` is high for cycles 1–17.
- Unsigned 0xFFFF × 0xFFFF → `prod_hi`=0xFFFE, `prod_lo`=0x0001.
- 0x0000 × 0x1234, then back-to-back 0x8000 × 0x0002 started in the first IDLE cycle → first result 0x0000_0000; second result `prod_hi`=0x0001, `prod_lo`=0x0000, `done` 18 cycles after the first `done`.
- `MUL_SIGNED_EN`, `sgn`=1, 0xFFFD × 0x0005 (−3 × 5) → 0xFFFF_FFF1 with `done` at cycle 21; 0xFFFD × 0xFFFB → 0x0000_000F with `done` at cycle 19.
- `start` pulsed at cycles 5 and 17 during an operation → ignored; result and `done` timing match the single-start case.
- `rst` asserted at cycle 8 of an operation → `busy`, `done`, `prod_*` and ALU drive go to reset values immediately; a new 7 × 7 started afterward gives 0x0000_0031.
